// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-period symbols, disparity type and a byte popcount.
package tmds_pkg;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    typedef logic signed [4:0] tmds_disp_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Transition-minimising stage: chains XOR or XNOR across the byte, q_m[8] flags which was used.
module tmds_qm_stage
    import tmds_pkg::*;
(
    input  logic [7:0] d_in,
    output logic [8:0] q_m
);

    logic [3:0] n1;
    logic       use_xnor;

    always_comb begin
        n1       = popcount8(d_in);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d_in[0]);
        q_m      = 9'd0;
        q_m[0]   = d_in[0];
        for (int i = 1; i < 8; i++) begin
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ d_in[i]) : (q_m[i-1] ^ d_in[i]);
        end
        q_m[8] = !use_xnor;
    end

endmodule

// File: rtl/dvi_tmds_encoder.sv
// One TMDS channel: q_m stage, running-disparity balancing and control symbols, one register stage.
module dvi_tmds_encoder
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       data_enable,
    input  logic       C0,
    input  logic       C1,
    input  logic [7:0] d_in,
    output logic [9:0] q_out
);

    logic [8:0] q_m;
    logic [3:0] n1_qm;
    logic [4:0] n1_x2;
    tmds_disp_t disp_qm;
    tmds_disp_t cnt_q, cnt_d;
    logic [9:0] q_out_q, q_out_d;
    logic       cnt_pos, cnt_neg, disp_pos, disp_neg;

    tmds_qm_stage u_qm_stage (
        .d_in (d_in),
        .q_m  (q_m)
    );

    // disp_qm = N1 - N0 = 2*N1 - 8, always within +/-8
    always_comb begin
        n1_qm   = popcount8(q_m[7:0]);
        n1_x2   = {n1_qm, 1'b0};
        disp_qm = tmds_disp_t'(n1_x2 - 5'd8);
    end

    always_comb begin
        cnt_neg  = cnt_q[4];
        cnt_pos  = !cnt_q[4] && (cnt_q != 5'sd0);
        disp_neg = disp_qm[4];
        disp_pos = !disp_qm[4] && (disp_qm != 5'sd0);
        q_out_d  = q_out_q;
        cnt_d    = cnt_q;

        if (!data_enable) begin
            cnt_d = 5'sd0;
            unique case ({C1, C0})
                2'b00:   q_out_d = CTRL_00;
                2'b01:   q_out_d = CTRL_01;
                2'b10:   q_out_d = CTRL_10;
                default: q_out_d = CTRL_11;
            endcase
        end else if ((cnt_q == 5'sd0) || (disp_qm == 5'sd0)) begin
            q_out_d = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
            cnt_d   = q_m[8] ? (cnt_q + disp_qm) : (cnt_q - disp_qm);
        end else if ((cnt_pos && disp_pos) || (cnt_neg && disp_neg)) begin
            q_out_d = {1'b1, q_m[8], ~q_m[7:0]};
            cnt_d   = cnt_q + tmds_disp_t'({3'b000, q_m[8], 1'b0}) - disp_qm;
        end else begin
            q_out_d = {1'b0, q_m[8], q_m[7:0]};
            cnt_d   = cnt_q + disp_qm - tmds_disp_t'({3'b000, ~q_m[8], 1'b0});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_out_q <= 10'd0;
            cnt_q   <= 5'sd0;
        end else begin
            q_out_q <= q_out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q_out = q_out_q;

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Directed scoreboard bench for dvi_tmds_encoder with hand-derived expected symbols.
module tb_dvi_tmds_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_enable = 1'b0;
    logic       C0 = 1'b0;
    logic       C1 = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic [9:0] q_out;

    typedef struct {
        logic [9:0] exp;
        bit         trans;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    dvi_tmds_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .data_enable (data_enable),
        .C0          (C0),
        .C1          (C1),
        .d_in        (d_in),
        .q_out       (q_out)
    );

    always #5 clk = ~clk;

    function automatic int n_trans(input logic [9:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            if (v[i] != v[i+1]) n++;
        end
        return n;
    endfunction

    task automatic drive(input logic r, input logic de, input logic c1, input logic c0,
                         input logic [7:0] d, input logic [9:0] exp, input bit tr,
                         input string nm);
        exp_t e;
        @(negedge clk);
        rst         = r;
        data_enable = de;
        C1          = c1;
        C0          = c0;
        d_in        = d;
        e.exp   = exp;
        e.trans = tr;
        e.name  = nm;
        sb.push_back(e);
    endtask

    // Monitor: every symbol driven is due one rising edge later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                checks++;
                if (q_out !== mon_e.exp) begin
                    failures++;
                    $display("FAIL %s: q_out=%b expected=%b", mon_e.name, q_out, mon_e.exp);
                end
                if (mon_e.trans) begin
                    checks++;
                    if (n_trans(q_out) > 5) begin
                        failures++;
                        $display("FAIL %s_trans: transitions=%0d expected<=5", mon_e.name,
                                 n_trans(q_out));
                    end
                end
            end
        end
    end

    initial begin
        drive(1, 0, 0, 0, 8'h00, 10'b0000000000, 0, "reset0");
        drive(1, 1, 1, 1, 8'hFF, 10'b0000000000, 0, "reset1");
        drive(0, 0, 0, 0, 8'h5A, 10'b1101010100, 0, "ctrl00");
        drive(0, 0, 0, 1, 8'hC3, 10'b0010101011, 0, "ctrl01");
        drive(0, 0, 1, 0, 8'hFF, 10'b0101010100, 0, "ctrl10");
        drive(0, 0, 1, 1, 8'h00, 10'b1010101011, 0, "ctrl11");

        drive(0, 0, 0, 0, 8'h00, 10'b1101010100, 0, "t3_ctrl");
        drive(0, 1, 0, 0, 8'h00, 10'b0100000000, 0, "t3_00a");
        drive(0, 1, 0, 0, 8'h00, 10'b1111111111, 0, "t3_00b");

        drive(0, 0, 0, 0, 8'h00, 10'b1101010100, 0, "t4_ctrl");
        drive(0, 1, 0, 0, 8'hFF, 10'b1000000000, 0, "t4_ff");

        drive(0, 0, 0, 0, 8'h00, 10'b1101010100, 0, "t5_ctrl");
        drive(0, 1, 0, 0, 8'hAA, 10'b1000110011, 1, "t5_aa");
        drive(0, 1, 0, 0, 8'h55, 10'b0100110011, 1, "t5_55");
        drive(0, 1, 0, 0, 8'hF0, 10'b1000000101, 1, "t5_f0");
        drive(0, 1, 0, 0, 8'h99, 10'b0101110111, 1, "t5_99");
        drive(0, 1, 0, 0, 8'h00, 10'b0100000000, 1, "t5_00");
        drive(0, 1, 0, 0, 8'hFF, 10'b0011111111, 1, "t5_ff");
        drive(0, 1, 0, 0, 8'hA7, 10'b0000110111, 1, "t5_a7");
        drive(0, 1, 0, 0, 8'h18, 10'b1111110111, 1, "t5_18");
        drive(0, 1, 0, 0, 8'hAA, 10'b1000110011, 1, "t5_aa2");
        // Disparity is +6 here; 0x99 encodes differently unless control cleared it.
        drive(0, 0, 1, 0, 8'h00, 10'b0101010100, 0, "t5_ctrl2");
        drive(0, 1, 0, 0, 8'h99, 10'b0101110111, 0, "t5_cnt_cleared");

        drive(0, 0, 0, 1, 8'h00, 10'b0010101011, 0, "tog_ctrl_a");
        drive(0, 1, 0, 0, 8'h00, 10'b0100000000, 0, "tog_data_a");
        drive(0, 0, 0, 1, 8'h00, 10'b0010101011, 0, "tog_ctrl_b");
        drive(0, 1, 0, 0, 8'h00, 10'b0100000000, 0, "tog_data_b");

        drive(0, 1, 0, 0, 8'h00, 10'b1111111111, 0, "t6_pre");
        drive(0, 1, 0, 0, 8'h00, 10'b0100000000, 0, "t6_cnt_m8");
        drive(1, 1, 0, 0, 8'h00, 10'b0000000000, 0, "t6_rst");
        drive(0, 1, 0, 0, 8'h00, 10'b0100000000, 0, "t6_restart");
        drive(1, 0, 1, 1, 8'h00, 10'b0000000000, 0, "rst_over_ctrl");
        drive(0, 0, 1, 1, 8'h00, 10'b1010101011, 0, "post_rst_ctrl");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
